// File: rtl/shift_arbiter_pkg.sv
// Shared encodings for the two-requester shifter arbiter: operation fields and requester ids.
package shift_arbiter_pkg;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic {
    MODE_ROTATE = 1'b0,
    MODE_SHIFT  = 1'b1
  } mode_e;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  localparam logic ARITH_ON = 1'b1;

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Combinational barrel shifter: logical/arithmetic shift and rotate in either direction.
module shift_arbiter_shifter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BITS  = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] operand_i,
  input  logic [BITS-1:0]  amount_i,
  input  dir_e             dir_i,
  input  mode_e            mode_i,
  input  logic             arith_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] sra;
  logic [WIDTH-1:0] ror;
  logic [WIDTH-1:0] rol;

  assign shr = operand_i >> amount_i;
  assign shl = operand_i << amount_i;
  assign sra = $signed(operand_i) >>> amount_i;
  // A shift by WIDTH yields zero, so amount 0 rotates back to the operand itself.
  assign ror = shr | (operand_i << (WIDTH - int'(amount_i)));
  assign rol = shl | (operand_i >> (WIDTH - int'(amount_i)));

  always_comb begin
    result_o = operand_i;
    if (mode_i == MODE_ROTATE) begin
      result_o = (dir_i == DIR_LEFT) ? rol : ror;
    end else if (dir_i == DIR_LEFT) begin
      result_o = shl;
    end else begin
      result_o = (arith_i == ARITH_ON) ? sra : shr;
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one shifter between two requesters, with a one-deep response register.
module shift_arbiter
  import shift_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BITS  = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [WIDTH-1:0] i_req0_operand,
  input  logic [BITS-1:0]  i_req0_amount,
  input  logic             i_req0_dir,
  input  logic             i_req0_mode,
  input  logic             i_req0_arith,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [WIDTH-1:0] i_req1_operand,
  input  logic [BITS-1:0]  i_req1_amount,
  input  logic             i_req1_dir,
  input  logic             i_req1_mode,
  input  logic             i_req1_arith,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_id
);

  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  req_id_e          id_q, id_d;
  req_id_e          ptr_q, ptr_d;

  logic             can_grant;
  logic             gnt0, gnt1;
  logic [WIDTH-1:0] sel_operand;
  logic [BITS-1:0]  sel_amount;
  dir_e             sel_dir;
  mode_e            sel_mode;
  logic             sel_arith;
  logic [WIDTH-1:0] shift_result;

  assign can_grant = (!rsp_valid_q || i_rsp_ready) && i_rst_n;
  assign gnt0 = can_grant && i_req0_valid && (!i_req1_valid || ptr_q == REQ0);
  assign gnt1 = can_grant && i_req1_valid && (!i_req0_valid || ptr_q == REQ1);

  assign o_req0_ready = gnt0;
  assign o_req1_ready = gnt1;

  always_comb begin
    sel_operand = i_req0_operand;
    sel_amount  = i_req0_amount;
    sel_dir     = dir_e'(i_req0_dir);
    sel_mode    = mode_e'(i_req0_mode);
    sel_arith   = i_req0_arith;
    if (gnt1) begin
      sel_operand = i_req1_operand;
      sel_amount  = i_req1_amount;
      sel_dir     = dir_e'(i_req1_dir);
      sel_mode    = mode_e'(i_req1_mode);
      sel_arith   = i_req1_arith;
    end
  end

  shift_arbiter_shifter #(
    .WIDTH (WIDTH),
    .BITS  (BITS)
  ) u_shifter (
    .operand_i (sel_operand),
    .amount_i  (sel_amount),
    .dir_i     (sel_dir),
    .mode_i    (sel_mode),
    .arith_i   (sel_arith),
    .result_o  (shift_result)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    result_d    = result_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    if (gnt0) begin
      rsp_valid_d = 1'b1;
      result_d    = shift_result;
      id_d        = REQ0;
      ptr_d       = REQ1;
    end else if (gnt1) begin
      rsp_valid_d = 1'b1;
      result_d    = shift_result;
      id_d        = REQ1;
      ptr_d       = REQ0;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rsp_valid_q <= 1'b0;
      result_q    <= '0;
      id_q        <= REQ0;
      ptr_q       <= REQ0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      result_q    <= result_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_result = result_q;
  assign o_rsp_id     = id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed bench for shift_arbiter against a bit-level behavioural model.
module tb_shift_arbiter;

  localparam int W = 32;
  localparam int B = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         v0, v1, rsp_ready;
  logic [W-1:0] op0, op1;
  logic [B-1:0] amt0, amt1;
  logic         dir0, dir1, mode0, mode1, ar0, ar1;
  logic         rdy0, rdy1, rsp_valid, rsp_id;
  logic [W-1:0] rsp_result;

  int unsigned  n_cmp = 0;
  int unsigned  n_err = 0;

  logic         m_valid = 1'b0;
  logic [W-1:0] m_result = '0;
  logic         m_id = 1'b0;
  logic         m_ptr = 1'b0;
  logic         last_g0 = 1'b0;
  logic         last_g1 = 1'b0;
  logic [W-1:0] saved;

  always #5 clk = ~clk;

  shift_arbiter #(.WIDTH(W), .BITS(B)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_req0_valid   (v0),
    .o_req0_ready   (rdy0),
    .i_req0_operand (op0),
    .i_req0_amount  (amt0),
    .i_req0_dir     (dir0),
    .i_req0_mode    (mode0),
    .i_req0_arith   (ar0),
    .i_req1_valid   (v1),
    .o_req1_ready   (rdy1),
    .i_req1_operand (op1),
    .i_req1_amount  (amt1),
    .i_req1_dir     (dir1),
    .i_req1_mode    (mode1),
    .i_req1_arith   (ar1),
    .o_rsp_valid    (rsp_valid),
    .i_rsp_ready    (rsp_ready),
    .o_rsp_result   (rsp_result),
    .o_rsp_id       (rsp_id)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Bit-by-bit definition of each operation.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] op, input int amt,
                                             input logic dir, input logic mode, input logic arith);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) begin
      if (!mode) r[i] = dir ? op[(i - amt + W) % W] : op[(i + amt) % W];
      else if (dir) r[i] = (i >= amt) ? op[(i - amt + W) % W] : 1'b0;
      else r[i] = (i + amt < W) ? op[(i + amt) % W] : (arith ? op[W-1] : 1'b0);
    end
    return r;
  endfunction

  // Entered just after a negedge with inputs already driven; returns at the next negedge.
  task automatic cycle();
    logic g0, g1, free;
    #1;
    free = !m_valid || rsp_ready;
    g0 = 1'b0;
    g1 = 1'b0;
    if (rst_n && free) begin
      if (v0 && v1) begin
        if (m_ptr) g1 = 1'b1; else g0 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    check("ready0", W'(rdy0), W'(g0));
    check("ready1", W'(rdy1), W'(g1));
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_result = '0; m_id = 1'b0; m_ptr = 1'b0;
    end else if (g0) begin
      m_valid = 1'b1; m_id = 1'b0; m_ptr = 1'b1;
      m_result = ref_shift(op0, int'(amt0), dir0, mode0, ar0);
    end else if (g1) begin
      m_valid = 1'b1; m_id = 1'b1; m_ptr = 1'b0;
      m_result = ref_shift(op1, int'(amt1), dir1, mode1, ar1);
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    last_g0 = g0;
    last_g1 = g1;
    #1;
    check("rsp_valid", W'(rsp_valid), W'(m_valid));
    check("rsp_result", rsp_result, m_result);
    check("rsp_id", W'(rsp_id), W'(m_id));
    @(negedge clk);
  endtask

  task automatic rand_req(input int k);
    if (k == 0) begin
      op0 = $urandom; amt0 = B'($urandom); dir0 = 1'($urandom);
      mode0 = 1'($urandom); ar0 = 1'($urandom);
    end else begin
      op1 = $urandom; amt1 = B'($urandom); dir1 = 1'($urandom);
      mode1 = 1'($urandom); ar1 = 1'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    rand_req(0);
    rand_req(1);
    @(negedge clk);

    // Reset with req0 asking
    v0 = 1'b1;
    repeat (2) begin
      cycle();
      check("rst_ready0", W'(rdy0), '0);
      check("rst_valid", W'(rsp_valid), '0);
    end

    // Single arithmetic right shift
    rst_n = 1'b1; rsp_ready = 1'b1;
    op0 = 32'h8000_0000; amt0 = 5'd4; dir0 = 1'b0; mode0 = 1'b1; ar0 = 1'b1;
    cycle();
    check("single_valid", W'(rsp_valid), 32'd1);
    check("single_result", rsp_result, 32'hF800_0000);
    check("single_id", W'(rsp_id), '0);
    v0 = 1'b0;
    cycle();

    // Contention right after reset
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    v0 = 1'b1; op0 = 32'h1; amt0 = 5'd31; dir0 = 1'b1; mode0 = 1'b1; ar0 = 1'b0;
    v1 = 1'b1; op1 = 32'h1; amt1 = 5'd1;  dir1 = 1'b0; mode1 = 1'b0; ar1 = 1'b0;
    cycle();
    check("cont0_id", W'(rsp_id), '0);
    check("cont0_result", rsp_result, 32'h8000_0000);
    v0 = 1'b0;
    cycle();
    check("cont1_id", W'(rsp_id), 32'd1);
    check("cont1_result", rsp_result, 32'h8000_0000);

    // Backpressure: hold three cycles, then drain and accept together
    v1 = 1'b0; v0 = 1'b1; rand_req(0);
    cycle();
    saved = rsp_result;
    rand_req(0); rsp_ready = 1'b0;
    repeat (3) begin
      cycle();
      check("bp_ready0", W'(rdy0), '0);
      check("bp_hold", rsp_result, saved);
    end
    rsp_ready = 1'b1;
    cycle();
    check("bp_release_valid", W'(rsp_valid), 32'd1);
    v0 = 1'b0;
    cycle();

    // Fairness from a fresh pointer
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("fair_id", W'(rsp_id), W'(i % 2));
      if (last_g0) rand_req(0);
      if (last_g1) rand_req(1);
    end

    // Reset while a response is pending
    v0 = 1'b0; rsp_ready = 1'b0;
    cycle();
    check("pending_valid", W'(rsp_valid), 32'd1);
    rst_n = 1'b0; v1 = 1'b0;
    cycle();
    check("midrst_valid", W'(rsp_valid), '0);
    rst_n = 1'b1; rsp_ready = 1'b1;
    cycle();
    check("midrst_no_replay", W'(rsp_valid), '0);
    v0 = 1'b1; v1 = 1'b1; rand_req(0); rand_req(1);
    cycle();
    check("midrst_first_id", W'(rsp_id), '0);

    // Random traffic obeying the hold-while-waiting rule
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      if (!(v0 && !last_g0)) begin
        v0 = ($urandom_range(0, 3) != 0);
        rand_req(0);
      end
      if (!(v1 && !last_g1)) begin
        v1 = ($urandom_range(0, 3) != 0);
        rand_req(1);
      end
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits.
REQ-002 SHALL have parameter BITS, default $clog2(WIDTH), the shift-amount width.
REQ-003 SHALL have port i_clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have, for each requester k in {0,1}, port i_reqk_valid  input  1  request k presents an operation.
REQ-006 SHALL have, for each k, port o_reqk_ready  output  1  request k is accepted this cycle.
REQ-007 SHALL have, for each k, port i_reqk_operand  input  WIDTH  the value to shift.
REQ-008 SHALL have, for each k, port i_reqk_amount  input  BITS  the shift/rotate distance.
REQ-009 SHALL have, for each k, ports i_reqk_dir, i_reqk_mode, i_reqk_arith  input  1 each  direction (0 right, 1 left), mode (0 rotate, 1 shift), arithmetic select (1 arithmetic).
REQ-010 SHALL have port o_rsp_valid  output  1  the response register holds a result.
REQ-011 SHALL have port i_rsp_ready  input  1  the consumer takes the response this cycle.
REQ-012 SHALL have port o_rsp_result  output  WIDTH  the registered shifter result.
REQ-013 SHALL have port o_rsp_id  output  1  the requester (0/1) that owns o_rsp_result.

Function
REQ-014 SHALL share one shifter datapath between the two requesters; it sees only the granted requester's fields.
REQ-015 SHALL define the output slot as free when o_rsp_valid=0 or i_rsp_ready=1.
REQ-016 SHALL grant at most one requester per cycle, and only while the slot is free and i_rst_n=1.
REQ-017 SHALL grant the only valid requester when exactly one requester is valid.
REQ-018 SHALL, when both requesters are valid, grant the requester named by a one-bit priority pointer.
REQ-019 SHALL, after each grant, set the pointer to the requester that was not granted (round-robin).
REQ-020 SHALL drive o_reqk_ready = grant_k combinationally; a handshake is valid and ready high at the same edge.
REQ-021 SHALL, on a handshake at edge N, capture the shifter result, o_rsp_id=k and o_rsp_valid=1 at edge N; latency is 1 cycle.
REQ-022 SHALL hold o_rsp_result and o_rsp_id stable while o_rsp_valid=1 and i_rsp_ready=0.
REQ-023 SHALL clear o_rsp_valid at an edge with i_rsp_ready=1 and no new grant.
REQ-024 SHALL, on drain plus new grant in the same cycle, load the new result with o_rsp_valid staying 1 (full throughput, 1 op per cycle).
REQ-025 SHALL require each requester to hold its fields stable while valid=1 and ready=0, and SHALL not check this.
REQ-026 SHALL produce shift/rotate results defined by the shifter (amount 0 returns the operand unchanged for every mode).

Reset
REQ-027 SHALL, at an edge with i_rst_n=0, set o_rsp_valid=0, o_rsp_result=0, o_rsp_id=0 and priority pointer=0.
REQ-028 SHALL hold both o_reqk_ready low while i_rst_n=0.
REQ-029 SHALL discard any pending response when reset is asserted mid-operation; the result is never re-presented.

Structure
REQ-030 SHALL take the direction, mode and arithmetic encodings and the requester-id constants from the shared shifter package.
REQ-031 SHALL instantiate exactly one shifter sub-module with WIDTH and BITS passed through; the arbiter itself contains no shifting logic.

Verification
REQ-032 SHALL cover reset: i_rst_n=0 for 2 cycles with i_req0_valid=1 -> o_req0_ready=0 and o_rsp_valid=0 throughout.
REQ-033 SHALL cover a single request: req0 operand 0x80000000, amount 4, shift, right, arith -> next cycle o_rsp_valid=1, result 0xF8000000, id 0.
REQ-034 SHALL cover contention: req0 (0x00000001, amount 31, shift left) and req1 (0x00000001, amount 1, rotate right) both valid after reset, i_rsp_ready=1 -> id 0 result 0x80000000, then the next cycle id 1 result 0x80000000.
REQ-035 SHALL cover backpressure: i_rsp_ready=0 for 3 cycles with the response held -> readies low and result unchanged; at release -> drain and new accept in the same cycle.
REQ-036 SHALL cover fairness: both requesters valid for 6 cycles, i_rsp_ready=1 -> o_rsp_id sequence 0,1,0,1,0,1.
REQ-037 SHALL cover reset mid-operation: i_rst_n=0 while o_rsp_valid=1 -> o_rsp_valid=0 next cycle, and the first contention after reset grants req0.
